// File: rtl/nvram_pkg.sv
// nvram_pkg: definitions shared by the NVRAM upload path.
//   state_e      - upload FSM states (idle / RAM fetch / one-cycle result publish)
//   FILL_DEFAULT - byte returned for unmapped addresses and RAM timeouts
//   CNT_W        - width of the ram_ack timeout counter
package nvram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDone
    } state_e;

    localparam logic [7:0]  FILL_DEFAULT = 8'hFF;
    localparam int unsigned CNT_W        = 8;

endpackage

// File: rtl/nvram_csum.sv
// nvram_csum: 8-bit running sum (mod 256) of NVRAM bytes delivered during an upload session.
// Built only when NVRAM_UPLOAD_CSUM_EN is defined; otherwise this file is empty.
//   i_clk      system clock
//   i_reset_n  synchronous active-low reset (clears the sum)
//   i_upload   upload session level; the sum clears on its rising edge
//   i_add      add i_byte to the sum this cycle
//   i_byte     byte to accumulate
//   o_sum      current sum
`ifdef NVRAM_UPLOAD_CSUM_EN
module nvram_csum (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_upload,
    input  logic       i_add,
    input  logic [7:0] i_byte,
    output logic [7:0] o_sum
);

    logic       r_upload;
    logic [7:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_upload <= 1'b0;
            r_sum    <= 8'h00;
        end else begin
            r_upload <= i_upload;
            if (i_upload && !r_upload) begin
                r_sum <= 8'h00;
            end else if (i_add) begin
                r_sum <= r_sum + i_byte;
            end
        end
    end

    assign o_sum = r_sum;

endmodule
`endif

// File: rtl/nvram_upload.sv
// nvram_upload: serves hps_io upload reads from the core's NVRAM through a shared RAM port.
// Optional feature: NVRAM_UPLOAD_CSUM_EN adds a checksum byte readable at address SIZE.
//   clk_sys       system clock
//   reset_n       synchronous active-low reset
//   ioctl_upload  upload session active (level)
//   ioctl_rd      one-cycle read strobe for ioctl_addr
//   ioctl_addr    requested byte address
//   ioctl_din     returned byte (holds last value)
//   ioctl_wait    high while a RAM fetch is pending
//   ram_req       RAM read request, held until ack/timeout/abort
//   ram_addr      RAM byte address
//   ram_ack       one-cycle ack, ram_data valid in the same cycle
//   ram_data      RAM read data
//   pause_cpu     stall request to the game CPU
module nvram_upload
    import nvram_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned SIZE    = 1024,
    parameter logic [7:0]  FILL    = FILL_DEFAULT,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_ack,
    input  logic [7:0]        ram_data,
    output logic              pause_cpu
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    state_e            r_state, w_state_d;
    logic [7:0]        r_din, w_din_d;
    logic              r_req, w_req_d;
    logic              r_wait, w_wait_d;
    logic [ADDR_W-1:0] r_addr, w_addr_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic              r_upload;
    logic              w_in_range;

    assign w_in_range = ioctl_addr < 25'(SIZE);

`ifdef NVRAM_UPLOAD_CSUM_EN
    logic       w_deliver;
    logic [7:0] w_deliver_byte;
    logic [7:0] w_sum;
    logic [7:0] w_csum_byte;
    logic       w_is_csum;

    // Same conditions under which the FSM publishes a RAM byte or a timeout FILL.
    assign w_deliver      = (r_state == StFetch) && ioctl_upload && (ram_ack || (r_cnt == TO_LIM));
    assign w_deliver_byte = ram_ack ? ram_data : FILL;
    // Two's complement so that image bytes plus this byte sum to zero.
    assign w_csum_byte    = ~w_sum + 8'd1;
    assign w_is_csum      = ioctl_addr == 25'(SIZE);

    nvram_csum u_csum (
        .i_clk     (clk_sys),
        .i_reset_n (reset_n),
        .i_upload  (ioctl_upload),
        .i_add     (w_deliver),
        .i_byte    (w_deliver_byte),
        .o_sum     (w_sum)
    );
`endif

    always_comb begin
        w_state_d = r_state;
        w_din_d   = r_din;
        w_req_d   = r_req;
        w_wait_d  = r_wait;
        w_addr_d  = r_addr;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (ioctl_rd && ioctl_upload) begin
                    if (w_in_range) begin
                        w_addr_d  = ioctl_addr[ADDR_W-1:0];
                        w_req_d   = 1'b1;
                        w_wait_d  = 1'b1;
                        w_cnt_d   = '0;
                        w_state_d = StFetch;
`ifdef NVRAM_UPLOAD_CSUM_EN
                    end else if (w_is_csum) begin
                        w_din_d = w_csum_byte;
`endif
                    end else begin
                        w_din_d = FILL;
                    end
                end
            end
            StFetch: begin
                // Abort takes priority over a coincident ack; that data is dropped.
                if (!ioctl_upload) begin
                    w_req_d   = 1'b0;
                    w_wait_d  = 1'b0;
                    w_state_d = StIdle;
                end else if (ram_ack) begin
                    w_din_d   = ram_data;
                    w_req_d   = 1'b0;
                    w_wait_d  = 1'b0;
                    w_state_d = StDone;
                end else if (r_cnt == TO_LIM) begin
                    w_din_d   = FILL;
                    w_req_d   = 1'b0;
                    w_wait_d  = 1'b0;
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_din    <= 8'h00;
            r_req    <= 1'b0;
            r_wait   <= 1'b0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_upload <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_din    <= w_din_d;
            r_req    <= w_req_d;
            r_wait   <= w_wait_d;
            r_addr   <= w_addr_d;
            r_cnt    <= w_cnt_d;
            r_upload <= ioctl_upload;
        end
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign ram_req    = r_req;
    assign ram_addr   = r_addr;
    assign pause_cpu  = r_upload | (r_state != StIdle);

endmodule
